// File: rtl/dmem_access_unit_if.sv
// Bundles the MEM-stage request inputs, the data-cache port and the MEM/WB-facing results of dmem_access_unit.
// The slave modport is the access unit; the master modport is its environment (pipeline plus cache).
interface dmem_access_unit_if;
   logic        mem_valid;
   logic        mem_read_op;
   logic        mem_write_op;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] store_data;
   logic        pipe_advance;
   logic [31:0] dmem_rdata;
   logic        dmem_resp;
   logic        dmem_read;
   logic        dmem_write;
   logic [31:0] dmem_address;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_mbe;
   logic [31:0] mem_data_out;
   logic        mem_stall;
   logic        misalign;

   modport slave (
      input  mem_valid, mem_read_op, mem_write_op, funct3, addr, store_data,
      input  pipe_advance, dmem_rdata, dmem_resp,
      output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe,
      output mem_data_out, mem_stall, misalign
   );

   modport master (
      output mem_valid, mem_read_op, mem_write_op, funct3, addr, store_data,
      output pipe_advance, dmem_rdata, dmem_resp,
      input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe,
      input  mem_data_out, mem_stall, misalign
   );
endinterface

// File: rtl/dmem_access_unit.sv
// MEM-stage data access: issues cache loads/stores, formats load data, stalls until the cache responds.
// Result lands in the resp cycle (zero extra cycles on a zero-wait cache); a resp under pipe_advance=0 is parked in HOLD.
module dmem_access_unit (
   input  logic              clk,
   input  logic              rst,
   dmem_access_unit_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] HOLD = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [31:0] hold_q, hold_d;

   logic [1:0]  b;
   logic        access, is_word, is_half, misal, op, in_req;
   logic        rd_req, wr_req, resp_fire;
   logic [31:0] rdata_shift;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_fmt;
   logic [3:0]  mbe;
   logic [31:0] data_out;

   assign b = bus.addr[1:0];

   always_comb begin
      is_word   = bus.funct3[1];
      is_half   = ~bus.funct3[1] & bus.funct3[0];
      access    = bus.mem_valid & (bus.mem_read_op | bus.mem_write_op);
      misal     = access & ((is_word & (b != 2'b00)) | (is_half & b[0]));
      op        = access & ~misal;
      // HOLD already owns a completed access, so the same instruction is never re-requested
      in_req    = (state_q == IDLE) || (state_q == WAIT);
      rd_req    = op & in_req & bus.mem_read_op;
      wr_req    = op & in_req & ~bus.mem_read_op & bus.mem_write_op;
      resp_fire = (rd_req | wr_req) & bus.dmem_resp;
   end

   always_comb begin
      rdata_shift = bus.dmem_rdata >> {b, 3'b000};
      ld_byte     = rdata_shift[7:0];
      ld_half     = bus.addr[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
      case (bus.funct3)
         3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  ld_fmt = {24'b0, ld_byte};
         3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
         3'b101:  ld_fmt = {16'b0, ld_half};
         default: ld_fmt = bus.dmem_rdata;
      endcase
   end

   always_comb begin
      mbe = 4'b0000;
      if (wr_req) begin
         case (bus.funct3[1:0])
            2'b00:   mbe = 4'b0001 << b;
            2'b01:   mbe = 4'b0011 << b;
            default: mbe = 4'b1111;
         endcase
      end
   end

   always_comb begin
      data_out = 32'b0;
      if (resp_fire && rd_req) begin
         data_out = ld_fmt;
      end else if (state_q == HOLD) begin
         data_out = hold_q;
      end
   end

   always_comb begin
      hold_d = hold_q;
      if (resp_fire) begin
         hold_d = rd_req ? ld_fmt : 32'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, WAIT: begin
            if (rd_req || wr_req) begin
               if (bus.dmem_resp) state_d = bus.pipe_advance ? IDLE : HOLD;
               else               state_d = WAIT;
            end else begin
               state_d = IDLE;
            end
         end
         HOLD:    if (bus.pipe_advance) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         hold_q  <= 32'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
      end
   end

   assign bus.dmem_read    = rd_req;
   assign bus.dmem_write   = wr_req;
   assign bus.dmem_address = {bus.addr[31:2], 2'b00};
   assign bus.dmem_wdata   = wr_req ? (bus.store_data << {b, 3'b000}) : 32'b0;
   assign bus.dmem_mbe     = mbe;
   assign bus.mem_data_out = data_out;
   assign bus.mem_stall    = (rd_req | wr_req) & ~bus.dmem_resp;
   assign bus.misalign     = misal;
endmodule

// File: doc/dmem_access_unit.md
# dmem_access_unit

Memory-stage data-access controller for the pipelined RV32I core. It sits between the EX/MEM stage registers and the MEM/WB stage registers. It issues load/store requests to the data cache and generates byte enables and shifted store data. It formats returned load data into `mem_data_out` for MEM/WB, and stalls the pipeline until the cache responds.

## Interface
- No parameters.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `mem_valid` in 1: MEM stage holds a valid instruction.
- `mem_read_op` in 1: instruction is a load.
- `mem_write_op` in 1: instruction is a store.
- `funct3` in 3: access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `addr` in 32: effective address (ALU output).
- `store_data` in 32: rs2 value.
- `pipe_advance` in 1: global stage-register load; 1 when the pipeline moves this cycle.
- `dmem_rdata` in 32: cache read data, valid with `dmem_resp`.
- `dmem_resp` in 1: cache completion.
- `dmem_read` out 1: cache read request.
- `dmem_write` out 1: cache write request.
- `dmem_address` out 32: `{addr[31:2],2'b00}`.
- `dmem_wdata` out 32: store data shifted to byte lane.
- `dmem_mbe` out 4: byte enables.
- `mem_data_out` out 32: formatted load result, to MEM/WB.
- `mem_stall` out 1: hold pipeline; forces `pipe_advance` low upstream.
- `misalign` out 1: current access is misaligned; no request issued.

## Operation
- FSM states: IDLE, WAIT, HOLD. Reset state is IDLE.
- `op` = `mem_valid & (mem_read_op | mem_write_op) & !misalign`.
- IDLE, `op`=1:
  - Assert `dmem_read`/`dmem_write` combinationally.
  - If `dmem_resp` is 0, go to WAIT.
  - If `dmem_resp` is 1, go to IDLE when `pipe_advance` is 1, otherwise to HOLD.
- WAIT:
  - Keep the request and all `dmem_*` outputs asserted and stable.
  - On `dmem_resp`, go to IDLE when `pipe_advance` is 1, otherwise to HOLD.
- HOLD:
  - No request; `mem_stall`=0.
  - `mem_data_out` is the captured register.
  - Go to IDLE on `pipe_advance`.
  - The same instruction is never re-issued.
- `mem_stall` = (`dmem_read | dmem_write`) & `!dmem_resp`.
- Load formatting uses `b = addr[1:0]`:
  - LB: sign-extend byte b.
  - LBU: zero-extend byte b.
  - LH: sign-extend half `addr[1]`.
  - LHU: zero-extend half `addr[1]`.
  - LW: full word.
- `mem_data_out` source:
  - In the resp cycle, formatted `dmem_rdata` (combinational), which is also captured into the hold register.
  - In HOLD, the hold register.
  - Otherwise 0.
  - Stores produce 0.
- Store byte enables: SB `4'b0001<<b`; SH `4'b0011<<b`; SW `4'b1111`.
- Store data: `dmem_wdata = store_data << (8*b)`. `dmem_wdata` is 0 when not writing.
- Misalignment:
  - LW/SW with `b`≠0 is misaligned.
  - LH/LHU/SH with `addr[0]`=1 is misaligned.
  - On misalignment: `misalign`=1, no request, `mem_stall`=0, `mem_data_out`=0.
- Requests are suppressed when `mem_valid`=0. Requests are also suppressed outside IDLE/WAIT.
- `mem_read_op` and `mem_write_op` both 1 is illegal; read takes priority.

## Timing
- Reset values: state IDLE, hold register 0. Consequently `dmem_read`, `dmem_write` and `mem_stall` are 0, and `mem_data_out`, `dmem_mbe`, `dmem_wdata` are 0 with no op.
- Latency:
  - Zero-wait cache (resp in the request cycle): no stall; result is valid the same cycle.
  - N-cycle cache: `mem_stall` is high for N cycles; result is valid in the resp cycle.
- Request outputs are held constant from first assertion through the resp cycle.
- `rst` in WAIT/HOLD: next state is IDLE, and the request drops after that edge. The cache shares `rst`, so no stale `dmem_resp` follows.
- Resp coinciding with `pipe_advance`=0 (another stage stalling): go to HOLD and keep the data until advance.
- `dmem_resp` while no request is asserted is ignored.

## Test plan
- LB, addr=0x1003, `dmem_rdata`=0x80112233, resp after 2 cycles:
  - `dmem_read` is held 3 cycles and `mem_stall` is 1 for 2 cycles.
  - `mem_data_out`=0xFFFFFF80 in the resp cycle.
- SH, addr=0x2002, `store_data`=0x0000BEEF, zero-wait:
  - `dmem_mbe`=0b1100, `dmem_wdata`=0xBEEF0000, `dmem_address`=0x2000.
  - `mem_stall` stays 0.
- LHU, addr=0x10, rdata=0x1234ABCD, resp with `pipe_advance`=0 for 2 cycles:
  - State goes to HOLD.
  - `mem_data_out` holds 0x0000ABCD with no further `dmem_read`, then returns to IDLE on advance.
- LW, addr=0x...2:
  - `misalign`=1, no request, `mem_stall`=0, `mem_data_out`=0.
- `rst` asserted in WAIT:
  - Next cycle state is IDLE and all outputs are 0 with `mem_valid`=0.
- Back-to-back SW then LW, both zero-wait:
  - Two single-cycle requests with no stall cycles.
